// File: rtl/calc_host_ctrl.sv
// Host-side sequencer for an iterative floating-point calculator. It launches one job,
// waits for done or timeout, and returns a single held response.
module calc_host_ctrl #(
    parameter logic [8:0]  IDLE_STATE   = 9'h001,
    parameter logic [8:0]  DONE_STATE   = 9'h100,
    parameter logic [15:0] TIMEOUT      = 16'd4095,
    parameter int unsigned ABORT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_mode,
    input  logic [31:0] req_operand,
    input  logic [31:0] req_n,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_timeout,
    output logic        calc_start,
    output logic        calc_reset,
    output logic [2:0]  calc_mode,
    output logic [31:0] calc_input,
    output logic [31:0] calc_n,
    input  logic [8:0]  calc_state,
    input  logic [31:0] calc_result,
    output logic        busy
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_ABORT, S_RESP} state_e;

    localparam logic [7:0] ABORT_LAST = 8'(ABORT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  abort_cnt_q, abort_cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    logic        calc_start_q, calc_start_d;
    logic        calc_reset_q, calc_reset_d;
    logic [2:0]  calc_mode_q, calc_mode_d;
    logic [31:0] calc_input_q, calc_input_d;
    logic [31:0] calc_n_q, calc_n_d;
    logic        busy_q, busy_d;

    logic [15:0] cnt_inc;
    logic        calc_done;
    logic        calc_running;
    logic        timeout_hit;

    assign cnt_inc      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign calc_done    = (calc_state == DONE_STATE);
    assign calc_running = (calc_state != IDLE_STATE);
    // Timeout fires on the edge where the counter reaches TIMEOUT.
    assign timeout_hit  = (cnt_inc == TIMEOUT);

    always_comb begin
        // NOTE: every *_d gets a default here so no path through the case infers a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        abort_cnt_d   = abort_cnt_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        rsp_timeout_d = rsp_timeout_q;
        calc_start_d  = 1'b0;
        calc_reset_d  = 1'b0;
        calc_mode_d   = calc_mode_q;
        calc_input_d  = calc_input_q;
        calc_n_d      = calc_n_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    calc_mode_d  = req_mode;
                    calc_input_d = req_operand;
                    calc_n_d     = req_n;
                    cnt_d        = 16'd0;
                    calc_start_d = 1'b1;
                    state_d      = S_START;
                end
            end
            S_START: begin
                cnt_d = cnt_inc;
                if (timeout_hit && !calc_done) begin
                    abort_cnt_d  = 8'd0;
                    calc_reset_d = 1'b1;
                    state_d      = S_ABORT;
                end else if (calc_running) begin
                    state_d = S_WAIT;
                end else begin
                    calc_start_d = 1'b1;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (calc_done) begin
                    rsp_result_d  = calc_result;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = S_RESP;
                end else if (timeout_hit) begin
                    abort_cnt_d  = 8'd0;
                    calc_reset_d = 1'b1;
                    state_d      = S_ABORT;
                end
            end
            S_ABORT: begin
                if (abort_cnt_q == ABORT_LAST) begin
                    rsp_result_d  = 32'h0;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = S_RESP;
                end else begin
                    abort_cnt_d  = abort_cnt_q + 8'd1;
                    calc_reset_d = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // The calculator stays in reset while this block is in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= 16'd0;
            abort_cnt_q   <= 8'd0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= 32'h0;
            rsp_timeout_q <= 1'b0;
            calc_start_q  <= 1'b0;
            calc_reset_q  <= 1'b1;
            calc_mode_q   <= 3'd0;
            calc_input_q  <= 32'h0;
            calc_n_q      <= 32'h0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            abort_cnt_q   <= abort_cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_timeout_q <= rsp_timeout_d;
            calc_start_q  <= calc_start_d;
            calc_reset_q  <= calc_reset_d;
            calc_mode_q   <= calc_mode_d;
            calc_input_q  <= calc_input_d;
            calc_n_q      <= calc_n_d;
            busy_q        <= busy_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_timeout = rsp_timeout_q;
    assign calc_start  = calc_start_q;
    assign calc_reset  = calc_reset_q;
    assign calc_mode   = calc_mode_q;
    assign calc_input  = calc_input_q;
    assign calc_n      = calc_n_q;
    assign busy        = busy_q;

endmodule
